game_sequencer: RTL and testbench

//  Top-level run controller for the horizon/obstacle datapath. Converts the VGA frame tick into
//  per-frame update pulses and owns game state (idle/running/crashed/restart).

---
 rtl/game_pkg.sv | 36 +++
 rtl/update_pacer.sv | 55 +++++
 rtl/game_sequencer.sv | 152 +++++++++++++++
 tb/tb_game_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-run types and default tuning constants; speed is SPEED_SCALE fixed point.
// Combinational helpers only, no state.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    CRASHED = 2'd2,
    RESTART = 2'd3
  } state_t;

  localparam int SPEED_SCALE        = 1024;
  localparam int SPEED_W            = 15;
  localparam int TIMER_W            = 6;

  localparam int DEF_INIT_SPEED     = 6144;
  localparam int DEF_MAX_SPEED      = 13312;
  localparam int DEF_ACCEL          = 1;
  localparam int DEF_CLEAR_FRAMES   = 180;
  localparam int DEF_FRAMES_PER_SEC = 60;
  localparam int DEF_RESTART_HOLD   = 45;
  localparam int DEF_UPDATE_GAP     = 4;

  // One extra bit of headroom so the sum can never wrap before clamping.
  function automatic logic [SPEED_W-1:0] speed_step(input logic [SPEED_W-1:0] cur,
                                                    input int accel,
                                                    input int max_speed);
    logic [SPEED_W:0] sum;
    sum = {1'b0, cur} + (SPEED_W+1)'(accel);
    if (sum > (SPEED_W+1)'(max_speed))
      speed_step = SPEED_W'(max_speed);
    else
      speed_step = sum[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/update_pacer.sv
// Turns frame ticks into update pulses at least UPDATE_GAP cycles apart; update is registered (1 cycle).
// One early tick is held pending; a tick arriving while one is pending is dropped and flagged sticky.
module update_pacer #(
  parameter int UPDATE_GAP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic enable,
  input  logic clear,
  output logic fire,
  output logic update,
  output logic pending,
  output logic overrun
);

  localparam int GW = $clog2(UPDATE_GAP + 1);

  logic [GW-1:0] gap_cnt;
  logic          busy;

  assign busy = (gap_cnt != '0);
  assign fire = enable && !busy && (frame_tick || pending);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= '0;
      update  <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      update <= fire;
      if (fire)
        gap_cnt <= GW'(UPDATE_GAP - 1);
      else if (busy)
        gap_cnt <= gap_cnt - GW'(1);

      if (clear) begin
        pending <= 1'b0;
        overrun <= 1'b0;
      end else if (!enable) begin
        pending <= 1'b0;
      end else begin
        // A pending frame is served first; any tick landing on top of it is lost.
        if (fire)
          pending <= 1'b0;
        else if (frame_tick)
          pending <= 1'b1;
        if (frame_tick && pending)
          overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Run controller: FSM idle/running/crashed/restart, speed ramp, frame timer and obstacle enable.
// All outputs registered; update trails an accepted frame tick by one cycle.
module game_sequencer
  import game_pkg::*;
#(
  parameter int INIT_SPEED     = DEF_INIT_SPEED,
  parameter int MAX_SPEED      = DEF_MAX_SPEED,
  parameter int ACCEL          = DEF_ACCEL,
  parameter int CLEAR_FRAMES   = DEF_CLEAR_FRAMES,
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int RESTART_HOLD   = DEF_RESTART_HOLD,
  parameter int UPDATE_GAP     = DEF_UPDATE_GAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               jump,
  input  logic               collision,
  output logic               start,
  output logic               restart,
  output logic               crash,
  output logic               update,
  output logic [TIMER_W-1:0] timer,
  output logic [SPEED_W-1:0] speed,
  output logic               has_obstacles,
  output logic               overrun
);

  localparam int FW = $clog2(CLEAR_FRAMES + 1);
  localparam int HW = $clog2(RESTART_HOLD + 1);

  state_t             state, state_nxt;
  logic [FW-1:0]      frame_cnt, frame_nxt;
  logic [HW-1:0]      hold_cnt, hold_nxt;
  logic               seen_low, seen_nxt;
  logic               start_nxt, restart_nxt, crash_nxt, has_nxt;
  logic [TIMER_W-1:0] timer_nxt;
  logic [SPEED_W-1:0] speed_nxt;
  logic               pacer_en, restart_go, fire, tick_pending, hold_done;

  update_pacer #(.UPDATE_GAP(UPDATE_GAP)) u_pacer (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (pacer_en),
    .clear      (restart_go),
    .fire       (fire),
    .update     (update),
    .pending    (tick_pending),
    .overrun    (overrun)
  );

  assign hold_done = (hold_cnt == HW'(RESTART_HOLD));

  always_comb begin
    state_nxt   = state;
    start_nxt   = 1'b0;
    restart_nxt = 1'b0;
    crash_nxt   = crash;
    has_nxt     = has_obstacles;
    timer_nxt   = timer;
    speed_nxt   = speed;
    frame_nxt   = frame_cnt;
    hold_nxt    = hold_cnt;
    seen_nxt    = seen_low;
    pacer_en    = 1'b0;
    restart_go  = 1'b0;

    case (state)
      IDLE: begin
        if (jump && !tick_pending) begin
          state_nxt = RUNNING;
          start_nxt = 1'b1;
          speed_nxt = SPEED_W'(INIT_SPEED);
          frame_nxt = '0;
        end
      end

      RUNNING: begin
        // Collision wins over a same-cycle tick: the pacer is disabled so the frame is discarded.
        pacer_en = !collision;
        if (collision) begin
          state_nxt = CRASHED;
          crash_nxt = 1'b1;
          hold_nxt  = '0;
          seen_nxt  = 1'b0;
        end else if (fire) begin
          timer_nxt = (timer == TIMER_W'(FRAMES_PER_SEC - 1)) ? '0 : timer + TIMER_W'(1);
          speed_nxt = speed_step(speed, ACCEL, MAX_SPEED);
          if (frame_cnt != FW'(CLEAR_FRAMES))
            frame_nxt = frame_cnt + FW'(1);
          if (frame_cnt == FW'(CLEAR_FRAMES - 1))
            has_nxt = 1'b1;
        end
      end

      CRASHED: begin
        if (frame_tick && !hold_done)
          hold_nxt = hold_cnt + HW'(1);
        // Restart needs a fresh press after the hold, so a held button never auto-restarts.
        if (hold_done && !jump)
          seen_nxt = 1'b1;
        if (hold_done && seen_low && jump) begin
          state_nxt   = RESTART;
          restart_nxt = 1'b1;
          restart_go  = 1'b1;
          crash_nxt   = 1'b0;
          has_nxt     = 1'b0;
          timer_nxt   = '0;
          speed_nxt   = SPEED_W'(INIT_SPEED);
          frame_nxt   = '0;
          hold_nxt    = '0;
          seen_nxt    = 1'b0;
        end
      end

      RESTART: begin
        state_nxt = RUNNING;
        start_nxt = 1'b1;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      start         <= 1'b0;
      restart       <= 1'b0;
      crash         <= 1'b0;
      has_obstacles <= 1'b0;
      timer         <= '0;
      speed         <= SPEED_W'(INIT_SPEED);
      frame_cnt     <= '0;
      hold_cnt      <= '0;
      seen_low      <= 1'b0;
    end else begin
      state         <= state_nxt;
      start         <= start_nxt;
      restart       <= restart_nxt;
      crash         <= crash_nxt;
      has_obstacles <= has_nxt;
      timer         <= timer_nxt;
      speed         <= speed_nxt;
      frame_cnt     <= frame_nxt;
      hold_cnt      <= hold_nxt;
      seen_low      <= seen_nxt;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed, table-driven bench for game_sequencer with hand-written corner-case sequences.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst, frame_tick, jump, collision;
  logic        start, restart, crash, update, has_obstacles, overrun;
  logic [5:0]  timer;
  logic [14:0] speed;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .jump          (jump),
    .collision     (collision),
    .start         (start),
    .restart       (restart),
    .crash         (crash),
    .update        (update),
    .timer         (timer),
    .speed         (speed),
    .has_obstacles (has_obstacles),
    .overrun       (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0, start_cnt = 0, restart_cnt = 0, clash_cnt = 0;
  int base;

  always @(posedge clk) begin
    #1;
    if (update)  upd_cnt++;
    if (start)   start_cnt++;
    if (restart) restart_cnt++;
    if ((update && (start || restart)) || (start && restart)) clash_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int sp);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (sp - 2) @(negedge clk);
  endtask

  typedef struct {
    int n;
    int sp;
    int exp_timer;
    int exp_speed;
    int exp_has;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b0; frame_tick = 1'b0; jump = 1'b0; collision = 1'b0;

    // cumulative updates: 1, 59, 60, 179, 180, 7167, 7168, 7200
    vecs[0] = '{1,    100, 1,  6145,  0};
    vecs[1] = '{58,   100, 59, 6203,  0};
    vecs[2] = '{1,    100, 0,  6204,  0};
    vecs[3] = '{119,  5,   59, 6323,  0};
    vecs[4] = '{1,    5,   0,  6324,  1};
    vecs[5] = '{6987, 5,   27, 13311, 1};
    vecs[6] = '{1,    5,   28, 13312, 1};
    vecs[7] = '{32,   5,   0,  13312, 1};

    #12;
    chk("reset_flags", int'({start, restart, crash, update, has_obstacles, overrun}), 0);
    chk("reset_timer", int'(timer), 0);
    chk("reset_speed", int'(speed), 6144);

    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    jump = 1'b1;
    @(negedge clk) jump = 1'b0;
    chk("start_pulse", int'(start), 1);
    chk("start_crash", int'(crash), 0);
    chk("start_speed", int'(speed), 6144);
    @(negedge clk);
    chk("start_width", int'(start), 0);
    repeat (20) @(negedge clk);
    chk("no_update_before_tick", upd_cnt, 0);
    chk("start_count", start_cnt, 1);

    for (int v = 0; v < 8; v++) begin
      base = upd_cnt;
      repeat (vecs[v].n) tick(vecs[v].sp);
      chk($sformatf("vec%0d_updates", v), upd_cnt - base, vecs[v].n);
      chk($sformatf("vec%0d_timer", v), int'(timer), vecs[v].exp_timer);
      chk($sformatf("vec%0d_speed", v), int'(speed), vecs[v].exp_speed);
      chk($sformatf("vec%0d_has_obstacles", v), int'(has_obstacles), vecs[v].exp_has);
    end

    // ticks two cycles apart: second delayed to gap expiry, third dropped
    base = upd_cnt;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    chk("gap_first_update", int'(update), 1);
    @(negedge clk) frame_tick = 1'b1;
    chk("gap_quiet_1", int'(update), 0);
    @(negedge clk) frame_tick = 1'b0;
    chk("gap_quiet_2", int'(update), 0);
    chk("gap_no_overrun_yet", int'(overrun), 0);
    @(negedge clk) frame_tick = 1'b1;
    chk("gap_quiet_3", int'(update), 0);
    @(negedge clk) frame_tick = 1'b0;
    chk("gap_delayed_update", int'(update), 1);
    chk("gap_overrun", int'(overrun), 1);
    repeat (10) @(negedge clk);
    chk("gap_update_count", upd_cnt - base, 2);
    chk("gap_timer", int'(timer), 2);

    // collision with tick in the same cycle
    base = upd_cnt;
    @(negedge clk) begin frame_tick = 1'b1; collision = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; collision = 1'b0; end
    chk("crash_level", int'(crash), 1);
    chk("crash_no_update", int'(update), 0);
    repeat (5) @(negedge clk);
    chk("crash_timer_frozen", int'(timer), 2);
    chk("crash_speed_frozen", int'(speed), 13312);

    for (int i = 1; i <= 45; i++) begin
      tick(20);
      if (i == 10) begin
        jump = 1'b1;
        repeat (3) @(negedge clk);
        jump = 1'b0;
      end
      if (i == 44) jump = 1'b1;
    end
    repeat (10) @(negedge clk);
    chk("held_jump_no_restart", int'(crash), 1);
    chk("restart_count_crashed", restart_cnt, 0);
    chk("crashed_no_updates", upd_cnt - base, 0);
    chk("crashed_has_obstacles", int'(has_obstacles), 1);

    jump = 1'b0;
    repeat (3) @(negedge clk);
    chk("release_no_restart", int'(crash), 1);
    jump = 1'b1;
    @(negedge clk);
    chk("restart_pulse", int'(restart), 1);
    chk("restart_not_start", int'(start), 0);
    chk("restart_crash_clear", int'(crash), 0);
    chk("restart_overrun_clear", int'(overrun), 0);
    chk("restart_has_clear", int'(has_obstacles), 0);
    chk("restart_timer", int'(timer), 0);
    chk("restart_speed", int'(speed), 6144);
    jump = 1'b0;
    @(negedge clk);
    chk("restart_then_start", int'(start), 1);
    chk("restart_width", int'(restart), 0);
    chk("restart_count", restart_cnt, 1);

    // async reset while a tick is pending
    tick(10);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    chk("pre_reset_timer", int'(timer), 2);
    #2 rst = 1'b0;
    #1;
    chk("midrun_reset_flags", int'({start, restart, crash, update, has_obstacles, overrun}), 0);
    chk("midrun_reset_timer", int'(timer), 0);
    chk("midrun_reset_speed", int'(speed), 6144);
    base = upd_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("pending_lost", upd_cnt - base, 0);
    chk("post_reset_idle", start_cnt, 2);
    chk("no_pulse_overlap", clash_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
